// File: rtl/posit_job_driver.sv
`timescale 1ns/1ps
// posit_job_driver
// Host-side initiator for the posit add accelerator job protocol.
// Takes an operand pair on a valid/ready job port and writes the
// operands little-endian into the accelerator source memory. It then
// raises start and waits for completed, with a timeout. The 32-bit
// result is read back byte-wise from the result memory and returned on
// a valid/ready response port.
//
// Ports:
//   clock, reset_n        : rising-edge clock, async active-low reset
//   job_valid/job_ready   : job handshake, operands job_num1/job_num2
//   src_address/src_write_data/src_write_enable : source memory write port
//   res_address/res_read_data : result memory read port (1-cycle latency)
//   acc_start/acc_completed   : accelerator start/completed levels
//   resp_valid/resp_ready     : response handshake
//   resp_result/resp_timeout  : result word and timeout flag
module posit_job_driver #(
  parameter int                ADDR_W         = 12,
  parameter logic [ADDR_W-1:0] SRC_BASE       = 12'h000,
  parameter logic [ADDR_W-1:0] RES_BASE       = 12'h010,
  parameter int                TIMEOUT_CYCLES = 4096
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              job_valid,
  output logic              job_ready,
  input  logic [31:0]       job_num1,
  input  logic [31:0]       job_num2,
  output logic [ADDR_W-1:0] src_address,
  output logic [7:0]        src_write_data,
  output logic              src_write_enable,
  output logic [ADDR_W-1:0] res_address,
  input  logic [7:0]        res_read_data,
  output logic              acc_start,
  input  logic              acc_completed,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_result,
  output logic              resp_timeout
);

  typedef enum logic [2:0] {IDLE, WRITE, ARM, WAIT, READ, RESP} state_t;

  // Final value of the wait counter; reaching it ends the job as a timeout.
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t            state_q, state_d;
  logic [63:0]       ops_q, ops_d;
  logic [2:0]        byte_cnt_q, byte_cnt_d;
  logic [2:0]        rd_cnt_q, rd_cnt_d;
  logic [15:0]       to_cnt_q, to_cnt_d;
  logic [ADDR_W-1:0] src_address_d;
  logic [7:0]        src_write_data_d;
  logic              src_write_enable_d;
  logic [ADDR_W-1:0] res_address_d;
  logic              acc_start_d;
  logic [31:0]       resp_result_d;
  logic              resp_timeout_d;
  logic [2:0]        next_byte;
  logic [1:0]        rd_byte;

  assign next_byte = byte_cnt_q + 3'd1;
  // Read data lags its address by one cycle, so the byte landing now
  // belongs to the address issued on the previous count.
  assign rd_byte   = rd_cnt_q[1:0] - 2'd1;

  assign job_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);

  // Registered state and outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q          <= IDLE;
      ops_q            <= '0;
      byte_cnt_q       <= '0;
      rd_cnt_q         <= '0;
      to_cnt_q         <= '0;
      src_address      <= '0;
      src_write_data   <= '0;
      src_write_enable <= 1'b0;
      res_address      <= '0;
      acc_start        <= 1'b0;
      resp_result      <= '0;
      resp_timeout     <= 1'b0;
    end else begin
      state_q          <= state_d;
      ops_q            <= ops_d;
      byte_cnt_q       <= byte_cnt_d;
      rd_cnt_q         <= rd_cnt_d;
      to_cnt_q         <= to_cnt_d;
      src_address      <= src_address_d;
      src_write_data   <= src_write_data_d;
      src_write_enable <= src_write_enable_d;
      res_address      <= res_address_d;
      acc_start        <= acc_start_d;
      resp_result      <= resp_result_d;
      resp_timeout     <= resp_timeout_d;
    end
  end

  // Next-state and next-output decode. Outputs are computed one cycle
  // ahead so that each registered output lines up with its state.
  always_comb begin
    state_d            = state_q;
    ops_d              = ops_q;
    byte_cnt_d         = byte_cnt_q;
    rd_cnt_d           = rd_cnt_q;
    to_cnt_d           = to_cnt_q;
    src_address_d      = src_address;
    src_write_data_d   = src_write_data;
    src_write_enable_d = 1'b0;
    res_address_d      = res_address;
    acc_start_d        = acc_start;
    resp_result_d      = resp_result;
    resp_timeout_d     = resp_timeout;

    case (state_q)
      IDLE: begin
        if (job_valid && job_ready) begin
          ops_d              = {job_num2, job_num1};
          byte_cnt_d         = 3'd0;
          src_write_enable_d = 1'b1;
          src_address_d      = SRC_BASE;
          src_write_data_d   = job_num1[7:0];
          state_d            = WRITE;
        end
      end

      WRITE: begin
        if (byte_cnt_q == 3'd7) begin
          state_d = ARM;
        end else begin
          byte_cnt_d         = next_byte;
          src_write_enable_d = 1'b1;
          src_address_d      = SRC_BASE + ADDR_W'(next_byte);
          src_write_data_d   = ops_q[{next_byte, 3'b000} +: 8];
        end
      end

      // A completed level left over from an earlier job must drop
      // before start is raised, otherwise it would be taken as ours.
      ARM: begin
        if (!acc_completed) begin
          acc_start_d = 1'b1;
          to_cnt_d    = 16'd0;
          state_d     = WAIT;
        end
      end

      WAIT: begin
        if (acc_completed) begin
          acc_start_d    = 1'b0;
          rd_cnt_d       = 3'd0;
          res_address_d  = RES_BASE;
          resp_timeout_d = 1'b0;
          state_d        = READ;
        end else if (to_cnt_q == TO_LAST) begin
          acc_start_d    = 1'b0;
          resp_timeout_d = 1'b1;
          resp_result_d  = 32'd0;
          state_d        = RESP;
        end else begin
          to_cnt_d = to_cnt_q + 16'd1;
        end
      end

      // Four addresses on counts 0..3, data captured on counts 1..4.
      READ: begin
        rd_cnt_d = rd_cnt_q + 3'd1;
        if (rd_cnt_q < 3'd3) begin
          res_address_d = RES_BASE + ADDR_W'(rd_cnt_q + 3'd1);
        end
        if (rd_cnt_q != 3'd0) begin
          resp_result_d[{rd_byte, 3'b000} +: 8] = res_read_data;
        end
        if (rd_cnt_q == 3'd4) begin
          state_d = RESP;
        end
      end

      RESP: begin
        if (resp_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule
